// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock and its key driver: lock-state,
// command and result codes, plus the driver's FSM state encoding.
package lock_pkg;

  localparam int CODE_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    LS_IN    = 2'b00,
    LS_OPEN  = 2'b01,
    LS_NEW   = 2'b10,
    LS_ALARM = 2'b11
  } lock_state_e;

  typedef enum logic [1:0] {
    OP_OPEN   = 2'b00,
    OP_CLOSE  = 2'b01,
    OP_CHANGE = 2'b10,
    OP_RSVD   = 2'b11
  } lock_op_e;

  typedef enum logic [1:0] {
    RES_OK        = 2'b00,
    RES_TIMEOUT   = 2'b01,
    RES_BAD_STATE = 2'b10,
    RES_ALARM     = 2'b11
  } lock_result_e;

  typedef enum logic [3:0] {
    DRV_IDLE      = 4'd0,
    DRV_CHECK     = 4'd1,
    DRV_SETUP     = 4'd2,
    DRV_STROBE    = 4'd3,
    DRV_WAIT      = 4'd4,
    DRV_NEWSET    = 4'd5,
    DRV_NEWSTROBE = 4'd6,
    DRV_NEWWAIT   = 4'd7,
    DRV_REPORT    = 4'd8
  } drv_state_e;

  // Lock state a command must find before it may strobe.
  function automatic lock_state_e start_state(input lock_op_e op);
    lock_state_e s;
    if (op == OP_CLOSE) s = LS_OPEN;
    else                s = LS_IN;
    return s;
  endfunction

  // Lock state that ends the first wait after the strobe.
  function automatic lock_state_e wait_target(input lock_op_e op);
    lock_state_e t;
    case (op)
      OP_OPEN:  t = LS_OPEN;
      OP_CLOSE: t = LS_IN;
      default:  t = LS_NEW;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lock_drv_timer.sv
// Loadable 8-bit up-counter with an expire flag; shared by the setup-hold and
// timeout phases of the key driver.
module lock_drv_timer
  import lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Saturates at all-ones so a stray increment can never wrap to zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = (count_q >= limit_i);

endmodule

// File: rtl/lock_key_driver.sv
// Drives a combination lock: presents the code on x, strobes it, waits for the
// lock to reach the expected state and reports the outcome with a done pulse.
module lock_key_driver
  import lock_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [CODE_W-1:0] cmd_code,
  input  logic [CODE_W-1:0] cmd_new,
  output logic              cmd_ready,
  input  logic [1:0]        lock_state,
  output logic [CODE_W-1:0] x,
  output logic              enter_pulse,
  output logic              change_pulse,
  output logic              done,
  output logic [1:0]        result,
  output drv_state_e        dbg_state,
  output logic [CNT_W-1:0]  dbg_count
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only in IDLE, and the operands are
  // captured on that edge and held unchanged until the command finishes.

  localparam logic [CNT_W-1:0] SETUP_LIMIT   = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYC);

  drv_state_e        state_q, state_d;
  lock_op_e          op_q, op_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] new_q, new_d;
  logic [CODE_W-1:0] x_q, x_d;
  lock_result_e      result_q, result_d;

  logic             tmr_load, tmr_inc, tmr_expire;
  logic [CNT_W-1:0] tmr_limit, tmr_count;
  lock_state_e      ls;

  assign ls = lock_state_e'(lock_state);

  // Setup phases compare against the hold length, wait phases against the timeout.
  assign tmr_limit = ((state_q == DRV_SETUP) || (state_q == DRV_NEWSET))
                     ? SETUP_LIMIT : TIMEOUT_LIMIT;

  lock_drv_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .inc_i      (tmr_inc),
    .load_val_i (CNT_W'(1)),
    .limit_i    (tmr_limit),
    .count_o    (tmr_count),
    .expire_o   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_OPEN;
      code_q   <= '0;
      new_q    <= '0;
      x_q      <= '0;
      result_q <= RES_OK;
    end else begin
      op_q     <= op_d;
      code_q   <= code_d;
      new_q    <= new_d;
      x_q      <= x_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    code_d   = code_q;
    new_d    = new_q;
    x_d      = x_q;
    result_d = result_q;
    tmr_load = 1'b0;
    tmr_inc  = 1'b0;
    unique case (state_q)
      DRV_IDLE: begin
        if (cmd_valid) begin
          op_d    = lock_op_e'(cmd_op);
          code_d  = cmd_code;
          new_d   = cmd_new;
          state_d = DRV_CHECK;
        end
      end
      DRV_CHECK: begin
        if ((op_q == OP_RSVD) || (ls != start_state(op_q))) begin
          result_d = RES_BAD_STATE;
          state_d  = DRV_REPORT;
        end else begin
          x_d      = code_q;
          tmr_load = 1'b1;
          state_d  = DRV_SETUP;
        end
      end
      DRV_SETUP: begin
        if (tmr_expire) state_d = DRV_STROBE;
        else            tmr_inc = 1'b1;
      end
      DRV_STROBE: begin
        tmr_load = 1'b1;
        state_d  = DRV_WAIT;
      end
      DRV_WAIT: begin
        // Alarm outranks reaching the target in the same cycle.
        if (ls == LS_ALARM) begin
          result_d = RES_ALARM;
          state_d  = DRV_REPORT;
        end else if (ls == wait_target(op_q)) begin
          if (op_q == OP_CHANGE) begin
            x_d      = new_q;
            tmr_load = 1'b1;
            state_d  = DRV_NEWSET;
          end else begin
            result_d = RES_OK;
            state_d  = DRV_REPORT;
          end
        end else if (tmr_expire) begin
          result_d = RES_TIMEOUT;
          state_d  = DRV_REPORT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      DRV_NEWSET: begin
        if (tmr_expire) state_d = DRV_NEWSTROBE;
        else            tmr_inc = 1'b1;
      end
      DRV_NEWSTROBE: begin
        tmr_load = 1'b1;
        state_d  = DRV_NEWWAIT;
      end
      DRV_NEWWAIT: begin
        if (ls == LS_ALARM) begin
          result_d = RES_ALARM;
          state_d  = DRV_REPORT;
        end else if (ls == LS_IN) begin
          result_d = RES_OK;
          state_d  = DRV_REPORT;
        end else if (tmr_expire) begin
          result_d = RES_TIMEOUT;
          state_d  = DRV_REPORT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      DRV_REPORT: begin
        state_d = DRV_IDLE;
      end
      default: begin
        state_d = DRV_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready    = 1'b0;
    enter_pulse  = 1'b0;
    change_pulse = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      DRV_IDLE:      cmd_ready = 1'b1;
      DRV_STROBE: begin
        if (op_q == OP_CHANGE) change_pulse = 1'b1;
        else                   enter_pulse  = 1'b1;
      end
      DRV_NEWSTROBE: enter_pulse = 1'b1;
      DRV_REPORT:    done        = 1'b1;
      default: ;
    endcase
  end

  assign x         = x_q;
  assign result    = result_q;
  assign dbg_state = state_q;
  assign dbg_count = tmr_count;

endmodule

// File: tb/tb_lock_key_driver.sv
// Bench for lock_key_driver: a behavioural lock responder plus a cycle-level
// reference of when strobes and done must appear and what they carry.
module tb_lock_key_driver;
  import lock_pkg::*;

  localparam int S = 2;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_code, cmd_new;
  logic       cmd_ready;
  logic [1:0] lock_state;
  logic [3:0] x;
  logic       enter_pulse, change_pulse, done;
  logic [1:0] result;
  drv_state_e dbg_state;
  logic [7:0] dbg_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [3:0] exp_x;
  logic [1:0] exp_last_res;

  lock_key_driver #(.SETUP_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_code     (cmd_code),
    .cmd_new      (cmd_new),
    .cmd_ready    (cmd_ready),
    .lock_state   (lock_state),
    .x            (x),
    .enter_pulse  (enter_pulse),
    .change_pulse (change_pulse),
    .done         (done),
    .result       (result),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Modes: 0 lock responds, 1 lock silent, 2 alarm after first strobe,
  // 3 respond to first strobe then alarm after the second.
  task automatic run_cmd(input int op, input logic [3:0] code, input logic [3:0] nw,
                         input int mode, input int d, input int d2, input bit hold);
    int a, s1, s2, exp_done, obs_done, pend_at, nstrobe, ready_viol, both_hi, n;
    logic [1:0] exp_res, obs_res, pend_val, tgt;
    logic [3:0] obs_x, nx_x;
    bit bad_st;
    int exp_cyc_q[$];
    logic [4:0] exp_q[$];
    int obs_cyc_q[$];
    logic [4:0] obs_q[$];
    @(negedge clk);
    total++;
    if (result !== exp_last_res) begin
      bad++; $display("FAIL result_hold: got %b want %b", result, exp_last_res);
    end
    total++;
    if (x !== exp_x) begin
      bad++; $display("FAIL x_idle_hold: got %b want %b", x, exp_x);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ready_idle: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_code = code; cmd_new = nw;
    a  = cyc;
    s1 = a + 2 + S;
    tgt = (op == 0) ? 2'b01 : (op == 1) ? 2'b00 : 2'b10;
    bad_st = (op == 3) || ((op == 1) ? (lock_state != 2'b01) : (lock_state != 2'b00));
    nx_x = exp_x;
    if (bad_st) begin
      exp_done = a + 2; exp_res = 2'b10;
    end else begin
      nx_x = code;
      exp_cyc_q.push_back(s1); exp_q.push_back({op == 2, code});
      if (mode == 1 || d > T) begin
        exp_done = s1 + T + 1; exp_res = 2'b01;
      end else if (mode == 2) begin
        exp_done = s1 + d + 1; exp_res = 2'b11;
      end else if (op != 2) begin
        exp_done = s1 + d + 1; exp_res = 2'b00;
      end else begin
        s2 = s1 + d + 1 + S;
        nx_x = nw;
        exp_cyc_q.push_back(s2); exp_q.push_back({1'b0, nw});
        if (d2 > T) begin
          exp_done = s2 + T + 1; exp_res = 2'b01;
        end else begin
          exp_done = s2 + d2 + 1; exp_res = (mode == 3) ? 2'b11 : 2'b00;
        end
      end
    end
    obs_done = -1; pend_at = -1; nstrobe = 0; ready_viol = 0; both_hi = 0;
    obs_res = 2'b00; obs_x = 4'h0; pend_val = 2'b00;
    for (int k = 0; k < 400 && obs_done < 0; k++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      if (cmd_ready) ready_viol++;
      if (enter_pulse && change_pulse) both_hi++;
      if (pend_at == cyc) begin lock_state = pend_val; pend_at = -1; end
      if (enter_pulse || change_pulse) begin
        obs_cyc_q.push_back(cyc); obs_q.push_back({change_pulse, x});
        nstrobe++;
        if (nstrobe == 1) begin
          pend_val = (mode == 2) ? 2'b11 : tgt;
          pend_at  = (mode == 1) ? -1 : cyc + d;
        end else begin
          pend_val = (mode == 3) ? 2'b11 : 2'b00;
          pend_at  = (mode == 0 || mode == 3) ? cyc + d2 : -1;
        end
      end
      if (done) begin obs_done = cyc; obs_res = result; obs_x = x; end
    end
    cmd_valid = 1'b0;
    total++;
    if (obs_done < 0) begin
      bad++; $display("FAIL done_missing: op=%0d no done within budget, want cycle %0d", op, exp_done - a);
    end else begin
      total++;
      if (obs_done != exp_done) begin
        bad++; $display("FAIL done_cycle: op=%0d got +%0d want +%0d", op, obs_done - a, exp_done - a);
      end
      if (obs_res !== exp_res) begin
        bad++; $display("FAIL result: op=%0d mode=%0d got %b want %b", op, mode, obs_res, exp_res);
      end
      total++;
      if (obs_x !== nx_x) begin
        bad++; $display("FAIL x_at_done: got %b want %b", obs_x, nx_x);
      end
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_cyc_q[i] != exp_cyc_q[i] || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL strobe%0d: got +%0d chg/x=%b want +%0d chg/x=%b",
                        i, obs_cyc_q[i] - a, obs_q[i], exp_cyc_q[i] - a, exp_q[i]);
      end
    end
    total++;
    if (ready_viol != 0 || both_hi != 0) begin
      bad++; $display("FAIL busy_outputs: ready_high=%0d both_pulses=%0d want 0 0", ready_viol, both_hi);
    end
    exp_x = nx_x;
    exp_last_res = exp_res;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_code = 4'h0; cmd_new = 4'h0;
    lock_state = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (x !== 4'h0 || enter_pulse !== 1'b0 || change_pulse !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: x=%b enter=%b change=%b want 0000 0 0", x, enter_pulse, change_pulse);
    end
    total++;
    if (done !== 1'b0 || result !== 2'b00) begin
      bad++; $display("FAIL reset_done: done=%b result=%b want 0 00", done, result);
    end
    total++;
    if (cmd_ready !== 1'b1 || dbg_state !== DRV_IDLE || dbg_count !== 8'd0) begin
      bad++; $display("FAIL reset_state: ready=%b state=%0d count=%0d want 1 0 0", cmd_ready, dbg_state, dbg_count);
    end
    exp_x = 4'h0; exp_last_res = 2'b00;
  endtask

  task automatic test_open_ok;
    lock_state = 2'b00;
    run_cmd(0, 4'b0110, 4'h0, 0, 3, 1, 1'b0);
  endtask

  task automatic test_close;
    run_cmd(1, 4'b0110, 4'h0, 0, $urandom_range(1, T), 1, 1'b0);
  endtask

  task automatic test_open_timeout_alarm;
    lock_state = 2'b00;
    run_cmd(0, 4'b0001, 4'h0, 1, 1, 1, 1'b0);
    run_cmd(0, 4'b0001, 4'h0, 2, $urandom_range(1, T), 1, 1'b0);
    lock_state = 2'b00;
  endtask

  task automatic test_change;
    lock_state = 2'b00;
    run_cmd(2, 4'b0110, 4'b1010, 0, 2, 3, 1'b0);
    run_cmd(0, 4'b1010, 4'h0, 0, $urandom_range(1, T), 1, 1'b0);
    run_cmd(1, 4'b1010, 4'h0, 0, $urandom_range(1, T), 1, 1'b0);
  endtask

  task automatic test_bad_state;
    lock_state = 2'b00;
    run_cmd(1, 4'b0110, 4'h0, 0, 2, 2, 1'b0);
    run_cmd(3, 4'b0110, 4'h0, 0, 2, 2, 1'b0);
  endtask

  task automatic test_back_to_back;
    lock_state = 2'b00;
    run_cmd(0, 4'($urandom), 4'h0, 0, $urandom_range(1, T), 1, 1'b1);
    run_cmd(1, 4'($urandom), 4'h0, 0, $urandom_range(1, T), 1, 1'b1);
    run_cmd(2, 4'($urandom), 4'($urandom), 0, $urandom_range(1, T), $urandom_range(1, T), 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      lock_state = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      run_cmd($urandom_range(0, 3), 4'($urandom), 4'($urandom), $urandom_range(0, 3),
              $urandom_range(1, T + 2), $urandom_range(1, T + 2), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    int s1, seen;
    lock_state = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_code = 4'b0110; cmd_new = 4'b1100;
    s1 = cyc + 2 + S;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cyc == s1) begin
        total++;
        if (change_pulse !== 1'b1) begin
          bad++; $display("FAIL mid_change_pulse: got %b want 1", change_pulse);
        end
      end
      if (cyc == s1 + 1) lock_state = 2'b10;
      if (cyc == s1 + 3) begin
        total++;
        if (dbg_state !== DRV_NEWSET || x !== 4'b1100) begin
          bad++; $display("FAIL mid_newset: state=%0d x=%b want %0d 1100", dbg_state, x, DRV_NEWSET);
        end
        rst = 1'b1; cmd_valid = 1'b0;
        break;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (x !== 4'h0 || done !== 1'b0 || cmd_ready !== 1'b1 || enter_pulse !== 1'b0) begin
      bad++; $display("FAIL mid_reset: x=%b done=%b ready=%b enter=%b want 0000 0 1 0", x, done, cmd_ready, enter_pulse);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || enter_pulse || change_pulse || !cmd_ready) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mid_abort_quiet: got %0d active cycles want 0", seen);
    end
    lock_state = 2'b00; exp_x = 4'h0; exp_last_res = 2'b00;
  endtask

  initial begin
    test_reset;
    test_open_ok;
    test_close;
    test_open_timeout_alarm;
    test_change;
    test_bad_state;
    test_back_to_back;
    test_random;
    test_reset_mid;
    test_open_ok;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
